// File: rtl/edge_event_arbiter.sv
// Purpose: detect enabled rise/fall edges on NUM_CH serial lines and serve them round-robin as one event stream.
// Latency: an edge sampled at clock E1 becomes pending and is presented on evt_valid_o after E2 (stage free, no winner ahead of it).
// Backpressure: the output stage holds its event while evt_ready_i is low; an edge on a slot that is still pending is dropped and flagged in ovf_o.
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] a_i,
    input  logic [NUM_CH-1:0] rise_en_i,
    input  logic [NUM_CH-1:0] fall_en_i,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [CH_W-1:0]   evt_ch_o,
    output logic              evt_type_o,
    output logic [NUM_CH-1:0] ovf_o,
    input  logic              ovf_clr_i
);

    // Slot s = 2*channel + type, type 1 = rise, 0 = fall.
    localparam int NS = 2 * NUM_CH;
    localparam int SW = $clog2(NS);

    logic [NUM_CH-1:0] a_ff_q;
    logic [NS-1:0]     pend_q, pend_d;
    logic [NS-1:0]     new_evt;
    logic [NS-1:0]     clr_mask;
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]     sel_slot;
    logic              sel_found;
    logic              stage_free;
    logic              do_load;
    logic              vld_q, vld_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              typ_q, typ_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d, ovf_set;

    // Enabled edges against the previous sample of each line.
    always_comb begin
        new_evt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            new_evt[2*c+1] = a_i[c] & ~a_ff_q[c] & rise_en_i[c];
            new_evt[2*c]   = ~a_i[c] & a_ff_q[c] & fall_en_i[c];
        end
    end

    // Round-robin pick: first pending slot at or above rr_ptr, wrapping at NS.
    always_comb begin
        int            idx;
        logic [SW-1:0] idx_s;
        idx       = 0;
        idx_s     = '0;
        sel_found = 1'b0;
        sel_slot  = '0;
        for (int i = 0; i < NS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NS) begin
                idx = idx - NS;
            end
            idx_s = SW'(idx);
            if (!sel_found && pend_q[idx_s]) begin
                sel_found = 1'b1;
                sel_slot  = idx_s;
            end
        end
    end

    assign stage_free = ~vld_q | evt_ready_i;
    assign do_load    = stage_free & sel_found;

    // Pending/overflow next state: a slot being loaded may take a new edge without overflowing.
    always_comb begin
        clr_mask = '0;
        for (int s = 0; s < NS; s++) begin
            clr_mask[s] = do_load && (sel_slot == SW'(s));
        end
        pend_d = (pend_q & ~clr_mask) | new_evt;
        for (int c = 0; c < NUM_CH; c++) begin
            ovf_set[c] = |(new_evt[2*c +: 2] & pend_q[2*c +: 2] & ~clr_mask[2*c +: 2]);
        end
        // A same-cycle overflow wins over the clear.
        ovf_d = (ovf_clr_i ? '0 : ovf_q) | ovf_set;
    end

    // Output stage and pointer advance on each load; the stage holds while stalled.
    always_comb begin
        vld_d    = vld_q;
        ch_d     = ch_q;
        typ_d    = typ_q;
        rr_ptr_d = rr_ptr_q;
        if (stage_free) begin
            vld_d = sel_found;
        end
        if (do_load) begin
            ch_d     = CH_W'(sel_slot >> 1);
            typ_d    = sel_slot[0];
            rr_ptr_d = (sel_slot == SW'(NS - 1)) ? '0 : sel_slot + SW'(1);
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_ff_q   <= '0;
            pend_q   <= '0;
            rr_ptr_q <= '0;
            vld_q    <= 1'b0;
            ch_q     <= '0;
            typ_q    <= 1'b0;
            ovf_q    <= '0;
        end else begin
            a_ff_q   <= a_i;
            pend_q   <= pend_d;
            rr_ptr_q <= rr_ptr_d;
            vld_q    <= vld_d;
            ch_q     <= ch_d;
            typ_q    <= typ_d;
            ovf_q    <= ovf_d;
        end
    end

    assign evt_valid_o = vld_q;
    assign evt_ch_o    = ch_q;
    assign evt_type_o  = typ_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus a randomized run.
// Expected values come from constants and a behavioural event model.
// Outputs are sampled on the falling clock edge.
module tb_edge_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int NS     = 2 * NUM_CH;
    localparam int VW     = 2 + CH_W + NUM_CH;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] a_i;
    logic [NUM_CH-1:0] rise_en_i;
    logic [NUM_CH-1:0] fall_en_i;
    logic              evt_valid_o;
    logic              evt_ready_i;
    logic [CH_W-1:0]   evt_ch_o;
    logic              evt_type_o;
    logic [NUM_CH-1:0] ovf_o;
    logic              ovf_clr_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: line history, pending event set, pointer, presented event.
    bit              m_prev [NUM_CH];
    bit              m_pend [NS];
    int              m_rr;
    bit              m_vld;
    int              m_ch;
    int              m_typ;
    bit [NUM_CH-1:0] m_ovf;

    edge_event_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_i        (a_i),
        .rise_en_i  (rise_en_i),
        .fall_en_i  (fall_en_i),
        .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i),
        .evt_ch_o   (evt_ch_o),
        .evt_type_o (evt_type_o),
        .ovf_o      (ovf_o),
        .ovf_clr_i  (ovf_clr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) m_prev[c] = 1'b0;
        for (int s = 0; s < NS; s++) m_pend[s] = 1'b0;
        m_rr  = 0;
        m_vld = 1'b0;
        m_ch  = 0;
        m_typ = 0;
        m_ovf = '0;
    endtask

    // One clock of the event model, using the inputs present at the rising edge.
    task automatic model_step();
        int win;
        int s;
        bit free;
        bit edge_seen;
        bit en;
        if (!reset) begin
            model_reset();
        end else begin
            free = !m_vld || evt_ready_i;
            win  = -1;
            if (free) begin
                for (int k = 0; k < NS; k++) begin
                    if (win < 0 && m_pend[(m_rr + k) % NS]) win = (m_rr + k) % NS;
                end
            end
            if (win >= 0) m_pend[win] = 1'b0;
            if (ovf_clr_i) m_ovf = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = 0; t < 2; t++) begin
                    edge_seen = (t == 1) ? (a_i[c] && !m_prev[c]) : (!a_i[c] && m_prev[c]);
                    en        = (t == 1) ? rise_en_i[c] : fall_en_i[c];
                    s         = 2 * c + t;
                    if (edge_seen && en) begin
                        if (m_pend[s]) m_ovf[c] = 1'b1;
                        m_pend[s] = 1'b1;
                    end
                end
            end
            if (free) begin
                m_vld = (win >= 0);
                if (win >= 0) begin
                    m_ch  = win / 2;
                    m_typ = win % 2;
                    m_rr  = (win + 1) % NS;
                end
            end
            for (int c = 0; c < NUM_CH; c++) m_prev[c] = a_i[c];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {evt_valid_o, evt_valid_o ? evt_ch_o : CH_W'(0),
                evt_valid_o ? evt_type_o : 1'b0, ovf_o};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        logic [CH_W-1:0] c;
        c = CH_W'(m_ch);
        return {m_vld, m_vld ? c : CH_W'(0), m_vld ? (m_typ == 1) : 1'b0, m_ovf};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        a_i         = '0;
        rise_en_i   = '0;
        fall_en_i   = '0;
        evt_ready_i = 1'b0;
        ovf_clr_i   = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        a_i         = 4'b0001;
        rise_en_i   = 4'b0001;
        fall_en_i   = '0;
        evt_ready_i = 1'b1;
        ovf_clr_i   = 1'b0;
        model_reset();
        tick();
        tick();
        n_checks++; if (evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", evt_valid_o); end
        n_checks++; if (evt_ch_o !== 2'd0) begin n_fail++; $display("FAIL reset_ch got=%0d exp=0", evt_ch_o); end
        n_checks++; if (evt_type_o !== 1'b0) begin n_fail++; $display("FAIL reset_type got=%b exp=0", evt_type_o); end
        n_checks++; if (ovf_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0000", ovf_o); end
        // a_i[0] already high at release counts as a rise.
        reset = 1'b1;
        tick();
        n_checks++; if (evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL release_e1_valid got=%b exp=0", evt_valid_o); end
        tick();
        n_checks++; if ({evt_valid_o, evt_ch_o, evt_type_o} !== {1'b1, 2'd0, 1'b1}) begin
            n_fail++; $display("FAIL release_rise got v/ch/t=%b/%0d/%b exp=1/0/1", evt_valid_o, evt_ch_o, evt_type_o); end
        tick();
        n_checks++; if (evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL release_after_valid got=%b exp=0", evt_valid_o); end
    endtask

    task automatic test_single_edge();
        bit exp_v;
        do_reset();
        evt_ready_i = 1'b1;
        rise_en_i   = 4'b0001;
        tick();
        a_i = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_v = (k == 2);
            n_checks++; if (evt_valid_o !== exp_v) begin n_fail++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", k, evt_valid_o, exp_v); end
            if (exp_v) begin
                n_checks++; if ({evt_ch_o, evt_type_o} !== {2'd0, 1'b1}) begin
                    n_fail++; $display("FAIL single_evt got ch/t=%0d/%b exp=0/1", evt_ch_o, evt_type_o); end
            end
            n_checks++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL single_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec()); end
        end
    endtask

    task automatic test_round_robin();
        bit              exp_v;
        logic [CH_W-1:0] exp_ch;
        do_reset();
        evt_ready_i = 1'b1;
        rise_en_i   = 4'b1111;
        a_i         = 4'b1111;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_v  = (k >= 2 && k <= 5);
            exp_ch = CH_W'(k - 2);
            n_checks++; if (evt_valid_o !== exp_v) begin n_fail++; $display("FAIL rr_valid cyc=%0d got=%b exp=%b", k, evt_valid_o, exp_v); end
            if (exp_v) begin
                n_checks++; if ({evt_ch_o, evt_type_o} !== {exp_ch, 1'b1}) begin
                    n_fail++; $display("FAIL rr_order cyc=%0d got ch/t=%0d/%b exp=%0d/1", k, evt_ch_o, evt_type_o, exp_ch); end
            end
            n_checks++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL rr_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec()); end
        end
    endtask

    task automatic test_backpressure();
        int accepts;
        do_reset();
        rise_en_i = 4'b0010;
        a_i       = 4'b0010;
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            n_checks++; if ({evt_valid_o, evt_ch_o, evt_type_o} !== {1'b1, 2'd1, 1'b1}) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got v/ch/t=%b/%0d/%b exp=1/1/1", k, evt_valid_o, evt_ch_o, evt_type_o); end
            tick();
        end
        evt_ready_i = 1'b1;
        accepts = 0;
        for (int k = 0; k < 4; k++) begin
            if (evt_valid_o && evt_ready_i) accepts++;
            tick();
            n_checks++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL bp_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec()); end
        end
        n_checks++; if (accepts != 1) begin n_fail++; $display("FAIL bp_accept_count got=%0d exp=1", accepts); end
    endtask

    task automatic test_overflow();
        int n_ch0, n_r2, n_f2, n_other;
        do_reset();
        rise_en_i = 4'b0101;
        fall_en_i = 4'b0100;
        a_i = 4'b0001; tick(); tick();      // ch0 rise occupies the stalled stage
        a_i = 4'b0101; tick();              // ch2 rise pending
        a_i = 4'b0001; tick();              // ch2 fall pending
        a_i = 4'b0101; tick();              // ch2 rise again while pending
        n_checks++; if (ovf_o !== 4'b0100) begin n_fail++; $display("FAIL ovf_set got=%b exp=0100", ovf_o); end
        evt_ready_i = 1'b1;
        n_ch0 = 0; n_r2 = 0; n_f2 = 0; n_other = 0;
        for (int k = 0; k < 6; k++) begin
            if (evt_valid_o && evt_ready_i) begin
                if (evt_ch_o == 2'd0 && evt_type_o) n_ch0++;
                else if (evt_ch_o == 2'd2 && evt_type_o) n_r2++;
                else if (evt_ch_o == 2'd2 && !evt_type_o) n_f2++;
                else n_other++;
            end
            tick();
            n_checks++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL ovf_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec()); end
        end
        n_checks++; if ({n_ch0, n_r2, n_f2, n_other} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
            n_fail++; $display("FAIL ovf_delivery got ch0r/ch2r/ch2f/other=%0d/%0d/%0d/%0d exp=1/1/1/0", n_ch0, n_r2, n_f2, n_other); end
        n_checks++; if (ovf_o !== 4'b0100) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=0100", ovf_o); end
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        n_checks++; if (ovf_o !== 4'b0000) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0000", ovf_o); end
    endtask

    task automatic test_fairness();
        int lat;
        bit seen;
        do_reset();
        evt_ready_i = 1'b1;
        rise_en_i   = 4'b1001;
        fall_en_i   = 4'b0001;
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < 40; k++) begin
            a_i[0] = ~a_i[0];
            if (k == 6) a_i[3] = 1'b1;
            tick();
            n_checks++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL fair_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec()); end
            if (k > 6 && !seen && evt_valid_o && evt_ch_o == 2'd3) begin
                seen = 1'b1;
                lat  = k - 6;
            end
        end
        n_checks++; if (!seen || lat > 2 * NUM_CH) begin
            n_fail++; $display("FAIL fair_latency got seen=%0d cycles=%0d exp seen=1 cycles<=%0d", seen, lat, 2 * NUM_CH); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        rise_en_i = 4'b1111;
        a_i = 4'b0001; tick(); tick();
        a_i = 4'b1111; tick(); tick();
        n_checks++; if ({evt_valid_o, evt_ch_o} !== {1'b1, 2'd0}) begin
            n_fail++; $display("FAIL mid_pre got v/ch=%b/%0d exp=1/0", evt_valid_o, evt_ch_o); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if ({evt_valid_o, evt_ch_o, evt_type_o, ovf_o} !== 8'd0) begin
            n_fail++; $display("FAIL mid_async_clear got v/ch/t/ovf=%b/%0d/%b/%b exp=0/0/0/0000", evt_valid_o, evt_ch_o, evt_type_o, ovf_o); end
        model_reset();
        a_i = '0;
        @(negedge clk);
        tick();
        reset       = 1'b1;
        evt_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++; if (evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_no_event cyc=%0d got=%b exp=0", k, evt_valid_o); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            a_i         = a_i ^ NUM_CH'($urandom & $urandom);
            rise_en_i   = NUM_CH'($urandom);
            fall_en_i   = NUM_CH'($urandom);
            evt_ready_i = ($urandom_range(0, 9) < 6);
            ovf_clr_i   = ($urandom_range(0, 19) == 0);
            tick();
            n_checks++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL random_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec()); end
        end
        ovf_clr_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_fairness();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
